bus_timer: RTL and testbench

Memory-mapped countdown timer that sits on the device side of the CPU system bridge at device slot 0 (addresses 0x0000_7F00–0x0000_7F0B). It decodes the bridge's shared address, write data and per-device hit strobe. It exposes three 32-bit registers (CTRL, PRESET, COUNT) and raises an interrupt request toward the CPU when a countdown expires. Two modes are supported: one-shot and auto-reload.

---
 rtl/bus_timer.sv | 201 ++++++++++++++++++++
 tb/tb_bus_timer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_timer.sv
`default_nettype none
// ============================================================================
// Module   : bus_timer
// Summary  : Memory-mapped countdown timer on bridge device slot 0.
//            Registers: CTRL (offset 0x0), PRESET (0x4), COUNT (0x8, RO).
//            One-shot and auto-reload modes; irq = IM & irq_flag.
// Revision : 1.0 - initial release
// ============================================================================
module bus_timer #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  // FSM encoding
  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_load = 2'd1;
  localparam logic [1:0] c_st_cnt  = 2'd2;
  localparam logic [1:0] c_st_int  = 2'd3;

  // Register offsets (addr[3:2])
  localparam logic [1:0] c_off_ctrl   = 2'd0;
  localparam logic [1:0] c_off_preset = 2'd1;
  localparam logic [1:0] c_off_count  = 2'd2;

  // Mode field value selecting auto-reload; every other value is one-shot
  localparam logic [1:0] c_mode_reload = 2'b01;

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq_flag;

  logic        w_enable;
  logic [1:0]  w_mode;
  logic        w_im;
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic        w_count_le1;

  // FSM action strobes
  logic        w_do_load;
  logic        w_do_dec;
  logic        w_do_expire;
  logic        w_do_oneshot_end;
  logic        w_do_reload_end;

  // The bridge has already decoded the device window; only addr[3:2] matter
  // here. The remaining address bits and the base parameter are folded into
  // a sink so that the full bus width stays on the port.
  logic        unused_ok;
  assign unused_ok = ^{addr[31:4], addr[1:0], ADDR_BASE};

  assign w_enable    = r_ctrl[0];
  assign w_mode      = r_ctrl[2:1];
  assign w_im        = r_ctrl[3];
  assign w_wr        = sel & we;
  assign w_wr_ctrl   = w_wr & (addr[3:2] == c_off_ctrl);
  assign w_wr_preset = w_wr & (addr[3:2] == c_off_preset);
  // PRESET = 0 and PRESET = 1 both expire on the first counting cycle
  assign w_count_le1 = (r_count <= 32'd1);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_enable) begin
          w_state_next = c_st_load;
        end
      end
      c_st_load: begin
        w_state_next = c_st_cnt;
      end
      c_st_cnt: begin
        if (!w_enable) begin
          w_state_next = c_st_idle;
        end else if (w_count_le1) begin
          w_state_next = c_st_int;
        end
      end
      c_st_int: begin
        w_state_next = c_st_idle;
      end
      default: begin
        w_state_next = c_st_idle;
      end
    endcase
  end

  // FSM output decode: per-state actions on the datapath registers
  always_comb begin
    w_do_load        = 1'b0;
    w_do_dec         = 1'b0;
    w_do_expire      = 1'b0;
    w_do_oneshot_end = 1'b0;
    w_do_reload_end  = 1'b0;
    case (r_state)
      c_st_load: begin
        w_do_load = 1'b1;
      end
      c_st_cnt: begin
        if (w_enable) begin
          w_do_expire = w_count_le1;
          w_do_dec    = ~w_count_le1;
        end
      end
      c_st_int: begin
        if (w_mode == c_mode_reload) begin
          w_do_reload_end = 1'b1;
        end else begin
          w_do_oneshot_end = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // CTRL register: a bus write takes priority over the one-shot Enable clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl <= 4'd0;
    end else if (w_wr_ctrl) begin
      r_ctrl <= din[3:0];
    end else if (w_do_oneshot_end) begin
      r_ctrl[0] <= 1'b0;
    end
  end

  // PRESET register: only sampled by the counter at LOAD
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_preset <= 32'd0;
    end else if (w_wr_preset) begin
      r_preset <= din;
    end
  end

  // COUNT register: load, decrement, clamp to zero on expiry, else hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= 32'd0;
    end else if (w_do_load) begin
      r_count <= r_preset;
    end else if (w_do_expire) begin
      r_count <= 32'd0;
    end else if (w_do_dec) begin
      r_count <= r_count - 32'd1;
    end
  end

  // Interrupt flag: a CTRL write acknowledges, and wins over a same-edge set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_flag <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_irq_flag <= 1'b0;
    end else if (w_do_expire) begin
      r_irq_flag <= 1'b1;
    end else if (w_do_reload_end) begin
      r_irq_flag <= 1'b0;
    end
  end

  // Combinational read mux; idle bus reads as zero
  always_comb begin
    dout = 32'd0;
    if (sel) begin
      case (addr[3:2])
        c_off_ctrl:   dout = {28'd0, r_ctrl};
        c_off_preset: dout = r_preset;
        c_off_count:  dout = r_count;
        default:      dout = 32'd0;
      endcase
    end
  end

  assign irq = w_im & r_irq_flag;

endmodule
`default_nettype wire

// File: tb/tb_bus_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_timer
// Summary  : Scoreboard bench for bus_timer. Stimulus drives one bus cycle per
//            clock and queues the expected dout/irq from a timeline model; a
//            negedge monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_timer;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        we;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int total = 0;
  int bad   = 0;

  bus_timer #(.ADDR_BASE(BASE)) dut (
    .clk  (clk),
    .reset(reset),
    .sel  (sel),
    .we   (we),
    .addr (addr),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Reference model. Rather than stepping a count register, a running
  // countdown is described by the edge it was loaded on and its start
  // value; the visible count is derived from elapsed edges.
  // Phases: 0 idle, 1 load pending, 2 counting, 3 expired.
  // ---------------------------------------------------------------------
  int          m_phase;
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_start;
  logic [31:0] m_held;
  longint      m_now;
  longint      m_load_edge;
  bit          m_flag;

  function automatic logic [31:0] m_count();
    if (m_phase == 2) return m_start - 32'(m_now - m_load_edge);
    return m_held;
  endfunction

  task automatic m_reset();
    m_phase = 0; m_ctrl = 4'd0; m_preset = 32'd0; m_start = 32'd0;
    m_held = 32'd0; m_flag = 1'b0; m_load_edge = 0;
  endtask

  // Advance the model across one rising edge carrying the given bus cycle
  task automatic m_edge(input bit s, input bit w, input logic [31:0] a,
                        input logic [31:0] d);
    logic [31:0] cur;
    logic [3:0]  c;
    cur = m_count();
    c   = m_ctrl;
    m_now++;
    case (m_phase)
      0: if (c[0]) m_phase = 1;
      1: begin m_phase = 2; m_start = m_preset; m_load_edge = m_now; end
      2: begin
        if (!c[0]) begin m_held = cur; m_phase = 0; end
        else if (cur <= 1) begin m_held = 32'd0; m_flag = 1'b1; m_phase = 3; end
      end
      default: begin
        if (c[2:1] == 2'b01) m_flag = 1'b0;
        else m_ctrl[0] = 1'b0;
        m_phase = 0;
      end
    endcase
    if (s && w) begin
      if (a[3:2] == 2'd0) begin m_ctrl = d[3:0]; m_flag = 1'b0; end
      else if (a[3:2] == 2'd1) m_preset = d;
    end
  endtask

  function automatic logic [31:0] m_read(input bit s, input logic [31:0] a);
    if (!s) return 32'd0;
    case (a[3:2])
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count();
      default: return 32'd0;
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  typedef struct {
    logic [31:0] d;
    logic        i;
  } exp_t;

  exp_t  sb[$];
  string sb_name[$];

  task automatic push(input string nm);
    exp_t e;
    e.d = m_read(sel, addr);
    e.i = m_ctrl[3] & m_flag;
    sb.push_back(e);
    sb_name.push_back(nm);
  endtask

  // Monitor: one observation per cycle, taken mid-cycle
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e  = sb.pop_front();
        nm = sb_name.pop_front();
        total++;
        if (dout !== e.d || irq !== e.i) begin
          bad++;
          $display("FAIL %s t=%0t: dout=%h irq=%b, expected dout=%h irq=%b",
                   nm, $time, dout, irq, e.d, e.i);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers (entered just after a rising edge)
  // ---------------------------------------------------------------------
  task automatic cyc(input string nm, input bit s, input bit w,
                     input logic [3:0] off, input logic [31:0] d);
    sel  = s;
    we   = w;
    addr = BASE | {26'd0, off, 2'(($urandom) & 3)};
    din  = d;
    push(nm);
    @(posedge clk);
    #1;
    m_edge(s, w, addr, d);
  endtask

  task automatic rd(input string nm, input logic [3:0] off);
    cyc(nm, 1'b1, 1'b0, off, $urandom);
  endtask

  task automatic wr(input string nm, input logic [3:0] off, input logic [31:0] d);
    cyc(nm, 1'b1, 1'b1, off, d);
  endtask

  // Asynchronous reset in the middle of a cycle, released before the next edge
  task automatic rst_mid(input string nm);
    sel = 1'b1; we = 1'b0; addr = BASE | 32'h8; din = 32'd0;
    reset = 1'b1;
    #1;
    m_reset();
    push(nm);
    @(negedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    m_edge(sel, we, addr, din);
  endtask

  // Run until the model shows a counting phase with the given count
  task automatic run_until_count(input string nm, input logic [31:0] v);
    for (int k = 0; k < 40; k++) begin
      if (m_phase == 2 && m_count() == v) break;
      rd(nm, 4'd2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; sel = 1'b0; we = 1'b0; addr = 32'd0; din = 32'd0;
    m_now = 0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    m_edge(1'b0, 1'b0, 32'd0, 32'd0);

    total++;
    if (dout !== m_read(sel, addr)) begin
      bad++;
      $display("FAIL post_reset_dout: dout=%h expected=%h", dout, m_read(sel, addr));
    end

    // Reset state on every offset
    for (int k = 0; k < 4; k++) rd("reset_read", 4'(k));

    // One-shot, PRESET = 5, IM set
    wr("os_preset", 4'd1, 32'd5);
    wr("os_ctrl", 4'd0, 32'h9);
    for (int k = 0; k < 10; k++) rd("os_count", 4'd2);

    total++;
    if (irq !== (m_ctrl[3] & m_flag) || dout !== m_read(sel, addr)) begin
      bad++;
      $display("FAIL os_expired: irq=%b dout=%h expected irq=%b dout=%h",
               irq, dout, m_ctrl[3] & m_flag, m_read(sel, addr));
    end

    rd("os_ctrl_rd", 4'd0);
    wr("os_ack", 4'd0, 32'h8);

    total++;
    if (irq !== (m_ctrl[3] & m_flag)) begin
      bad++;
      $display("FAIL os_ack_irq: irq=%b expected=%b", irq, m_ctrl[3] & m_flag);
    end

    rd("os_after_ack", 4'd2);
    rd("os_after_ack", 4'd0);

    // Auto-reload, PRESET = 3
    wr("ar_preset", 4'd1, 32'd3);
    wr("ar_ctrl", 4'd0, 32'hB);
    for (int k = 0; k < 24; k++) rd("ar_run", 4'((k % 2) * 2));
    wr("ar_stop", 4'd0, 32'h0);
    rd("ar_stop", 4'd0);

    // Disable mid-count, then re-enable
    wr("dis_preset", 4'd1, 32'd10);
    wr("dis_ctrl", 4'd0, 32'h9);
    run_until_count("dis_run", 32'd7);
    wr("dis_off", 4'd0, 32'h8);
    for (int k = 0; k < 5; k++) rd("dis_hold", 4'd2);
    wr("dis_on", 4'd0, 32'h9);
    for (int k = 0; k < 14; k++) rd("dis_reload", 4'd2);

    // Masked interrupt, then unmask via CTRL write (clears the flag)
    wr("msk_preset", 4'd1, 32'd4);
    wr("msk_ctrl", 4'd0, 32'h1);
    for (int k = 0; k < 9; k++) rd("msk_run", 4'd2);
    wr("msk_im", 4'd0, 32'h8);
    rd("msk_im", 4'd0);
    rd("msk_im", 4'd2);

    // Reset mid-count at COUNT = 2
    wr("rst_ctrl", 4'd0, 32'h9);
    run_until_count("rst_run", 32'd2);
    rst_mid("rst_mid");

    total++;
    if (dout !== m_read(sel, addr)) begin
      bad++;
      $display("FAIL rst_mid_count: dout=%h expected=%h", dout, m_read(sel, addr));
    end

    for (int k = 0; k < 4; k++) rd("rst_read", 4'(k));
    for (int k = 0; k < 4; k++) rd("rst_idle", 4'd2);

    // Ignored writes and deselected writes
    wr("ro_count", 4'd2, 32'h1234);
    wr("ro_off_c", 4'd3, 32'hFFFF_FFFF);
    rd("ro_count", 4'd2);
    rd("ro_off_c", 4'd3);
    cyc("nosel_wr", 1'b0, 1'b1, 4'd0, 32'hF);

    total++;
    if (dut.r_ctrl !== m_ctrl) begin
      bad++;
      $display("FAIL nosel_ctrl_reg: ctrl=%h expected=%h", dut.r_ctrl, m_ctrl);
    end

    rd("nosel_ctrl", 4'd0);

    // PRESET = 0 expires on the first counting cycle
    wr("p0_preset", 4'd1, 32'd0);
    wr("p0_ctrl", 4'd0, 32'hB);
    for (int k = 0; k < 10; k++) rd("p0_run", 4'd2);
    wr("p0_stop", 4'd0, 32'h0);

    // Randomized bus traffic
    for (int k = 0; k < 600; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 6)       wr("rnd_ctrl", 4'd0, $urandom);
      else if (r < 12) wr("rnd_preset", 4'd1, 32'($urandom_range(0, 12)));
      else if (r < 15) wr("rnd_ro", 4'($urandom_range(2, 3)), $urandom);
      else if (r < 18) cyc("rnd_nosel", 1'b0, 1'b1, 4'($urandom_range(0, 3)), $urandom);
      else if (r < 19) rst_mid("rnd_reset");
      else if (r < 24) cyc("rnd_idle", 1'b0, 1'b0, 4'($urandom_range(0, 3)), $urandom);
      else             rd("rnd_read", 4'($urandom_range(0, 3)));
    end

    sel = 1'b0; we = 1'b0;
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
